// File: rtl/resource_requester.sv
// Initiator front end for shared_resource: tags client commands with free IDs,
// tracks outstanding requests and reports per-ID data, address and round-trip latency.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module resource_requester #(
    parameter int NUM_TAGS  = 4,
    parameter int LAT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [`ADDRESS_WIDTH-1:0]         cmd_address,
    output logic [`ADDRESS_WIDTH-1:0]         req_address,
    output logic [`ID_WIDTH-1:0]              req_id,
    output logic                              req_valid,
    input  logic [`DATA_WIDTH-1:0]            resp_data,
    input  logic [`ID_WIDTH-1:0]              resp_id,
    input  logic                              resp_valid,
    output logic                              done_valid,
    output logic [`ID_WIDTH-1:0]              done_id,
    output logic [`ADDRESS_WIDTH-1:0]         done_address,
    output logic [`DATA_WIDTH-1:0]            done_data,
    output logic [LAT_WIDTH-1:0]              done_latency,
    output logic [$clog2(NUM_TAGS+1)-1:0]     outstanding,
    output logic                              err_spurious
);

    localparam int AW = `ADDRESS_WIDTH;
    localparam int IW = `ID_WIDTH;
    localparam int CW = $clog2(NUM_TAGS+1);

    typedef enum logic {
        TAG_FREE   = 1'b0,
        TAG_ISSUED = 1'b1
    } tag_state_t;

    tag_state_t              tag_state      [NUM_TAGS];
    tag_state_t              tag_state_next [NUM_TAGS];
    logic [NUM_TAGS-1:0]     busy;
    logic [AW-1:0]           addr_mem       [NUM_TAGS];
    logic [LAT_WIDTH-1:0]    ts_mem         [NUM_TAGS];
    logic [LAT_WIDTH-1:0]    counter;
    logic [IW-1:0]           alloc_id;
    logic                    alloc_found;
    logic                    accept;
    logic                    resp_match;
    logic [AW-1:0]           match_addr;
    logic [LAT_WIDTH-1:0]    match_ts;
    logic [CW-1:0]           busy_count;

    // Allocation and readiness look only at registered tag state, so a tag freed
    // by a response this cycle cannot be handed out until the next one.
    always_comb begin
        busy        = '0;
        alloc_id    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            busy[i] = (tag_state[i] == TAG_ISSUED);
            if (!busy[i] && !alloc_found) begin
                alloc_id    = IW'(i);
                alloc_found = 1'b1;
            end
        end
    end

    assign cmd_ready = alloc_found;
    assign accept    = cmd_valid && alloc_found;

    always_comb begin
        resp_match = 1'b0;
        match_addr = '0;
        match_ts   = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (resp_valid && resp_id == IW'(i) && busy[i]) begin
                resp_match = 1'b1;
                match_addr = addr_mem[i];
                match_ts   = ts_mem[i];
            end
        end
    end

    // Allocated and completed tags are always distinct (FREE vs ISSUED).
    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            tag_state_next[i] = tag_state[i];
            if (accept && alloc_id == IW'(i)) begin
                tag_state_next[i] = TAG_ISSUED;
            end else if (resp_match && resp_id == IW'(i)) begin
                tag_state_next[i] = TAG_FREE;
            end
            if (tag_state_next[i] == TAG_ISSUED) begin
                busy_count = busy_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                tag_state[i] <= TAG_FREE;
            end
            counter      <= '0;
            outstanding  <= '0;
            req_valid    <= 1'b0;
            req_id       <= '0;
            req_address  <= '0;
            done_valid   <= 1'b0;
            done_id      <= '0;
            done_address <= '0;
            done_data    <= '0;
            done_latency <= '0;
            err_spurious <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                tag_state[i] <= tag_state_next[i];
            end
            counter      <= counter + LAT_WIDTH'(1);
            outstanding  <= busy_count;
            req_valid    <= accept;
            done_valid   <= resp_match;
            err_spurious <= resp_valid && !resp_match;
            if (accept) begin
                req_id      <= alloc_id;
                req_address <= cmd_address;
            end
            if (resp_match) begin
                done_id      <= resp_id;
                done_address <= match_addr;
                done_data    <= resp_data;
                done_latency <= counter - match_ts;
            end
        end
    end

    // The timestamp is the counter value in the request cycle, one after acceptance.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (accept && alloc_id == IW'(i)) begin
                addr_mem[i] <= cmd_address;
                ts_mem[i]   <= counter + LAT_WIDTH'(1);
            end
        end
    end

endmodule
